sms_vram_ctrl: RTL and testbench
================================

Name: sms_vram_ctrl

Overview:
- Converts the VDP's multiplexed VRAM bus (AD/OE/WE0/WE1/CE) into accesses on a synchronous 8K x 16 block RAM.
- Shares that RAM with a host port used by the loader and savestate logic.
- Sits on the board beside the VDP and resolves the VRAM read path that currently returns a constant.
- The VDP has absolute priority; host accesses fill idle memory-issue slots.

Parameters:
- ADDR_W, 13, VRAM word-address width.
- READ_LATENCY, 2, MCLK cycles from mem_rden to valid mem_q (allowed range 1..4).

Ports:
- MCLK  in  1  system clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- vdp_AD_o  in  16  VDP AD output: address during the address phase, write data during writes.
- vdp_AD_d  in  1  low = VDP drives AD.
- vdp_CE  in  1  active-low VRAM cycle enable.
- vdp_OE  in  1  active-low read strobe.
- vdp_WE0  in  1  active-low write strobe, low byte.
- vdp_WE1  in  1  active-low write strobe, high byte.
- vdp_AD_i  out  16  read data to the VDP.
- vdp_rd_valid  out  1  high while vdp_AD_i holds valid read data.
- host_req  in  1  host access request; held until host_ack.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host word address.
- host_wdata  in  16  host write data.
- host_be  in  2  host byte enables; bit0 = [7:0], bit1 = [15:8].
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  16  host read data; valid while host_ack is high.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  16  RAM write data.
- mem_be  out  2  RAM byte enables.
- mem_wren  out  1  RAM write strobe (one cycle).
- mem_rden  out  1  RAM read strobe (one cycle).
- mem_q  in  16  RAM read data.

Behaviour:
- Input sampling:
  - All vdp_* inputs are registered once (stage s1) and the previous sample is kept (s2).
  - Edges are computed from s1/s2, so every VDP event is acted on 1 cycle after it appears.
- Reset values (RESET=0):
  - vdp_AD_i=0, vdp_rd_valid=0, host_ack=0, host_rdata=0.
  - mem_wren=0, mem_rden=0, mem_addr=0, mem_be=0, mem_wdata=0.
  - VDP FSM = V_IDLE, host FSM = H_IDLE, return-tag pipeline cleared.
- VDP FSM:
  - V_IDLE: on CE fall with AD_d=0, latch addr = AD_o[ADDR_W-1:0] -> V_ACTIVE. If CE falls with AD_d=1, stay in V_IDLE (cycle ignored).
  - V_ACTIVE:
    - OE fall -> issue mem_rden with the latched addr and mem_be=2'b11 -> V_RWAIT.
    - WE0 or WE1 fall with AD_d=0 -> issue mem_wren with mem_wdata=AD_o and mem_be={~WE1,~WE0} -> V_WDONE.
    - OE and WE falling in the same cycle: the write wins, the read is dropped.
  - V_RWAIT: when the tagged return arrives (READ_LATENCY cycles after issue), load vdp_AD_i=mem_q, set vdp_rd_valid=1 -> V_RHOLD.
  - V_RHOLD: hold the data until OE rises. OE rise -> V_ACTIVE (a further OE fall in the same CE cycle re-reads the same address). CE rise -> V_IDLE.
  - V_WDONE: ignore further WE edges until both WE strobes are high -> V_ACTIVE.
  - CE rise from any state -> V_IDLE, vdp_rd_valid=0.
  - A read already in flight still drains; its data is discarded if CE has risen.
- Host FSM:
  - H_IDLE: when host_req=1 and the memory port is free this cycle, issue the access -> H_BUSY. Free = no VDP issue in this cycle.
  - Write: mem_wren with mem_be=host_be; host_ack pulses the next cycle; -> H_IDLE.
  - Read: mem_rden; on the tagged return, host_rdata=mem_q and host_ack=1 for one cycle; -> H_IDLE.
  - At most one host access is outstanding.
- Memory issue:
  - At most one mem_rden or mem_wren per cycle; never both.
  - Priority: VDP issue > host issue. A host request blocked by a VDP issue retries the next cycle.
- Return routing:
  - A READ_LATENCY-deep tag shift register records {valid, owner} per read issue.
  - mem_q is routed by the tag only; untagged mem_q is ignored.
- Boundaries:
  - The address wraps naturally to ADDR_W bits; AD_o[15:ADDR_W] is ignored.
  - host_be=0 still issues mem_wren with mem_be=0 and still acks.
  - A reset asserted mid-access aborts it with no ack. The first access after release behaves normally.

Test Plan:
- VDP read: RAM[0x0123]=0xBEEF; CE fall with AD=0x0123, then OE fall -> mem_rden at +1 cycle, vdp_AD_i=0xBEEF with vdp_rd_valid=1 at +1+READ_LATENCY, held until CE rise, then vdp_rd_valid=0.
- VDP byte write: latch addr 0x1FFF, WE1 only with AD=0xA55A -> one mem_wren with mem_be=2'b10; a RAM readback gives 0xA5xx with the low byte unchanged.
- Contention: host read of 0x0004 is requested in the same cycle the VDP OE fall is acted on -> the VDP issues first; the host issues the next cycle and host_ack carries the correct data; vdp_AD_i is not corrupted.
- Host write then read: write 0x1234 to 0x0010 with be=3 -> ack after 1 cycle; read 0x0010 -> host_rdata=0x1234 with ack READ_LATENCY+1 cycles after the request.
- Abort: CE rises while a VDP read is in flight -> no vdp_rd_valid, and the stale data is not delivered to the host.
- Reset: RESET low during V_RWAIT with a host read pending -> all outputs 0, no ack; after release, a fresh host read completes normally.

Source files
------------

// File: rtl/sms_vram_ctrl.sv
`timescale 1ns/1ps
// sms_vram_ctrl: bridges the VDP's multiplexed VRAM bus onto a synchronous
// 8K x 16 block RAM and shares the spare memory slots with a host port.
// The VDP always wins the memory port; host accesses fill idle issue slots.
module sms_vram_ctrl #(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic              MCLK,
  input  logic              RESET,
  // VDP VRAM bus
  input  logic [15:0]       vdp_AD_o,
  input  logic              vdp_AD_d,
  input  logic              vdp_CE,
  input  logic              vdp_OE,
  input  logic              vdp_WE0,
  input  logic              vdp_WE1,
  output logic [15:0]       vdp_AD_i,
  output logic              vdp_rd_valid,
  // host port
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [15:0]       host_wdata,
  input  logic [1:0]        host_be,
  output logic              host_ack,
  output logic [15:0]       host_rdata,
  // block RAM port
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [15:0]       mem_q
);

  localparam int unsigned TAG_LAST = READ_LATENCY - 1;

  localparam logic [2:0] V_IDLE   = 3'd0;
  localparam logic [2:0] V_ACTIVE = 3'd1;
  localparam logic [2:0] V_RWAIT  = 3'd2;
  localparam logic [2:0] V_RHOLD  = 3'd3;
  localparam logic [2:0] V_WDONE  = 3'd4;

  localparam logic [0:0] H_IDLE = 1'b0;
  localparam logic [0:0] H_BUSY = 1'b1;

  // VDP input samples: s1 is the registered input, s2 the previous s1
  logic [15:0] s1_ad;
  logic        s1_ad_d;
  logic        s1_ce, s1_oe, s1_we0, s1_we1;
  logic        s2_ce, s2_oe, s2_we0, s2_we1;

  // edge strobes derived from the sample pair
  logic ce_fall, ce_rise, oe_fall, oe_rise, we_fall;

  // FSM state and latched context
  logic [2:0]        v_state, v_state_nx;
  logic [ADDR_W-1:0] v_addr, v_addr_nx;
  logic [0:0]        h_state, h_state_nx;
  logic              h_wr, h_wr_nx;

  // owner of the access currently on the memory port (1 = VDP)
  logic mem_own_vdp, m_own_vdp_nx;

  // return-tag pipeline, aligned so the last stage matches mem_q
  logic [READ_LATENCY-1:0] tag_vld;
  logic [READ_LATENCY-1:0] tag_vdp;
  logic                    ret_vdp, ret_host;

  // next values of the registered outputs
  logic [15:0]       ad_i_nx;
  logic              rd_valid_nx;
  logic              ack_nx;
  logic [15:0]       rdata_nx;
  logic [ADDR_W-1:0] m_addr_nx;
  logic [15:0]       m_wdata_nx;
  logic [1:0]        m_be_nx;
  logic              m_wren_nx, m_rden_nx;

  // issue decisions for this cycle
  logic vdp_rd, vdp_wr, host_go;

  // register the VDP bus; strobes reset inactive so no false edges follow reset
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      s1_ad   <= 16'h0000;
      s1_ad_d <= 1'b1;
      s1_ce   <= 1'b1;
      s1_oe   <= 1'b1;
      s1_we0  <= 1'b1;
      s1_we1  <= 1'b1;
      s2_ce   <= 1'b1;
      s2_oe   <= 1'b1;
      s2_we0  <= 1'b1;
      s2_we1  <= 1'b1;
    end else begin
      s1_ad   <= vdp_AD_o;
      s1_ad_d <= vdp_AD_d;
      s1_ce   <= vdp_CE;
      s1_oe   <= vdp_OE;
      s1_we0  <= vdp_WE0;
      s1_we1  <= vdp_WE1;
      s2_ce   <= s1_ce;
      s2_oe   <= s1_oe;
      s2_we0  <= s1_we0;
      s2_we1  <= s1_we1;
    end
  end

  // edge detection and return routing
  always_comb begin
    ce_fall  = s2_ce & ~s1_ce;
    ce_rise  = ~s2_ce & s1_ce;
    oe_fall  = s2_oe & ~s1_oe;
    oe_rise  = ~s2_oe & s1_oe;
    we_fall  = ((s2_we0 & ~s1_we0) | (s2_we1 & ~s1_we1)) & ~s1_ad_d;
    ret_vdp  = tag_vld[TAG_LAST] & tag_vdp[TAG_LAST] & (v_state == V_RWAIT);
    ret_host = tag_vld[TAG_LAST] & ~tag_vdp[TAG_LAST] & (h_state == H_BUSY) & ~h_wr;
  end

  // next-state and output decode for both FSMs and the memory issue mux
  always_comb begin
    v_state_nx   = v_state;
    v_addr_nx    = v_addr;
    ad_i_nx      = vdp_AD_i;
    rd_valid_nx  = vdp_rd_valid;
    h_state_nx   = h_state;
    h_wr_nx      = h_wr;
    ack_nx       = 1'b0;
    rdata_nx     = host_rdata;
    m_addr_nx    = mem_addr;
    m_wdata_nx   = mem_wdata;
    m_be_nx      = mem_be;
    m_wren_nx    = 1'b0;
    m_rden_nx    = 1'b0;
    m_own_vdp_nx = mem_own_vdp;
    vdp_rd       = 1'b0;
    vdp_wr       = 1'b0;
    host_go      = 1'b0;

    // VDP side: CE rise ends the cycle from any state
    if (ce_rise) begin
      v_state_nx  = V_IDLE;
      rd_valid_nx = 1'b0;
    end else begin
      case (v_state)
        V_IDLE: begin
          if (ce_fall && !s1_ad_d) begin
            v_addr_nx  = s1_ad[ADDR_W-1:0];
            v_state_nx = V_ACTIVE;
          end
        end
        V_ACTIVE: begin
          // a write strobe beats a simultaneous read strobe
          if (we_fall) begin
            vdp_wr     = 1'b1;
            v_state_nx = V_WDONE;
          end else if (oe_fall) begin
            vdp_rd      = 1'b1;
            rd_valid_nx = 1'b0;
            v_state_nx  = V_RWAIT;
          end
        end
        V_RWAIT: begin
          if (ret_vdp) begin
            ad_i_nx     = mem_q;
            rd_valid_nx = 1'b1;
            v_state_nx  = V_RHOLD;
          end
        end
        V_RHOLD: begin
          if (oe_rise) begin
            v_state_nx = V_ACTIVE;
          end
        end
        V_WDONE: begin
          if (s1_we0 && s1_we1) begin
            v_state_nx = V_ACTIVE;
          end
        end
        default: v_state_nx = V_IDLE;
      endcase
    end

    // host side: only issues into a slot the VDP leaves free
    host_go = (h_state == H_IDLE) & host_req & ~host_ack & ~(vdp_rd | vdp_wr);
    case (h_state)
      H_IDLE: begin
        if (host_go) begin
          h_wr_nx    = host_we;
          h_state_nx = H_BUSY;
        end
      end
      H_BUSY: begin
        if (h_wr) begin
          ack_nx     = 1'b1;
          h_state_nx = H_IDLE;
        end else if (ret_host) begin
          rdata_nx   = mem_q;
          ack_nx     = 1'b1;
          h_state_nx = H_IDLE;
        end
      end
      default: h_state_nx = H_IDLE;
    endcase

    // memory issue mux: at most one strobe per cycle, VDP first
    if (vdp_wr) begin
      m_addr_nx    = v_addr;
      m_wdata_nx   = s1_ad;
      m_be_nx      = {~s1_we1, ~s1_we0};
      m_wren_nx    = 1'b1;
      m_own_vdp_nx = 1'b1;
    end else if (vdp_rd) begin
      m_addr_nx    = v_addr;
      m_be_nx      = 2'b11;
      m_rden_nx    = 1'b1;
      m_own_vdp_nx = 1'b1;
    end else if (host_go) begin
      m_addr_nx    = host_addr;
      m_wdata_nx   = host_wdata;
      m_be_nx      = host_we ? host_be : 2'b11;
      m_wren_nx    = host_we;
      m_rden_nx    = ~host_we;
      m_own_vdp_nx = 1'b0;
    end
  end

  // state and output registers
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      v_state      <= V_IDLE;
      v_addr       <= '0;
      h_state      <= H_IDLE;
      h_wr         <= 1'b0;
      vdp_AD_i     <= 16'h0000;
      vdp_rd_valid <= 1'b0;
      host_ack     <= 1'b0;
      host_rdata   <= 16'h0000;
      mem_addr     <= '0;
      mem_wdata    <= 16'h0000;
      mem_be       <= 2'b00;
      mem_wren     <= 1'b0;
      mem_rden     <= 1'b0;
      mem_own_vdp  <= 1'b0;
    end else begin
      v_state      <= v_state_nx;
      v_addr       <= v_addr_nx;
      h_state      <= h_state_nx;
      h_wr         <= h_wr_nx;
      vdp_AD_i     <= ad_i_nx;
      vdp_rd_valid <= rd_valid_nx;
      host_ack     <= ack_nx;
      host_rdata   <= rdata_nx;
      mem_addr     <= m_addr_nx;
      mem_wdata    <= m_wdata_nx;
      mem_be       <= m_be_nx;
      mem_wren     <= m_wren_nx;
      mem_rden     <= m_rden_nx;
      mem_own_vdp  <= m_own_vdp_nx;
    end
  end

  // tag shift register; CE rise kills VDP reads still in flight
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      tag_vld <= '0;
      tag_vdp <= '0;
    end else begin
      tag_vld[0] <= mem_rden & ~(mem_own_vdp & ce_rise);
      tag_vdp[0] <= mem_own_vdp;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1] & ~(tag_vdp[i-1] & ce_rise);
        tag_vdp[i] <= tag_vdp[i-1];
      end
    end
  end

endmodule

// File: tb/tb_sms_vram_ctrl.sv
`timescale 1ns/1ps
// tb_sms_vram_ctrl: directed and randomized checks of the VDP/host VRAM bridge
// against a word-array model of RAM contents and the documented cycle timing.
module tb_sms_vram_ctrl;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned RL     = 2;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              MCLK = 1'b0;
  logic              RESET;
  logic [15:0]       vdp_AD_o;
  logic              vdp_AD_d, vdp_CE, vdp_OE, vdp_WE0, vdp_WE1;
  logic [15:0]       vdp_AD_i;
  logic              vdp_rd_valid;
  logic              host_req, host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [15:0]       host_wdata;
  logic [1:0]        host_be;
  logic              host_ack;
  logic [15:0]       host_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_be;
  logic              mem_wren, mem_rden;
  logic [15:0]       mem_q;

  int n_cmp = 0;
  int n_bad = 0;

  // environment RAM and the expected-contents reference
  logic [15:0] ram    [0:DEPTH-1];
  logic [15:0] shadow [0:DEPTH-1];
  logic [15:0] q_pipe [0:RL-1];
  bit          q_v    [0:RL-1];
  logic [15:0] junk;

  always #5 MCLK = ~MCLK;

  sms_vram_ctrl #(.ADDR_W(ADDR_W), .READ_LATENCY(RL)) dut (
    .MCLK(MCLK), .RESET(RESET),
    .vdp_AD_o(vdp_AD_o), .vdp_AD_d(vdp_AD_d), .vdp_CE(vdp_CE), .vdp_OE(vdp_OE),
    .vdp_WE0(vdp_WE0), .vdp_WE1(vdp_WE1), .vdp_AD_i(vdp_AD_i), .vdp_rd_valid(vdp_rd_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_be(host_be), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_q(mem_q)
  );

  // untagged cycles present random junk on mem_q
  assign mem_q = q_v[RL-1] ? q_pipe[RL-1] : junk;

  // synchronous RAM with RL cycles of read latency
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) ram[i] = 16'($urandom);
    forever begin
      @(posedge MCLK);
      if (mem_wren) begin
        if (mem_be[0]) ram[mem_addr][7:0]  <= mem_wdata[7:0];
        if (mem_be[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
      end
      q_pipe[0] <= ram[mem_addr];
      q_v[0]    <= mem_rden;
      for (int i = 1; i < int'(RL); i++) begin
        q_pipe[i] <= q_pipe[i-1];
        q_v[i]    <= q_v[i-1];
      end
      junk <= 16'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // the RAM port never carries a read and a write together
  always @(negedge MCLK) begin
    if (RESET === 1'b1) chk("mem_excl", 64'(mem_rden & mem_wren), 64'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  task automatic vdp_idle();
    vdp_CE = 1'b1; vdp_OE = 1'b1; vdp_WE0 = 1'b1; vdp_WE1 = 1'b1;
    vdp_AD_d = 1'b1; vdp_AD_o = 16'h0000;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_vdp"}, 64'({vdp_AD_i, vdp_rd_valid, host_ack, host_rdata}), 64'd0);
    chk({tag, "_mem"}, 64'({mem_addr, mem_wdata, mem_be, mem_wren, mem_rden}), 64'd0);
  endtask

  task automatic wait_issue(input string tag, output bit found);
    int k;
    found = 1'b0;
    k = 0;
    while (!found && k < 16) begin
      @(negedge MCLK);
      if (mem_wren || mem_rden) found = 1'b1;
      k++;
    end
    chk({tag, "_issue"}, 64'(found), 64'd1);
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic [1:0] be);
    bit found;
    @(negedge MCLK);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d; host_be = be;
    wait_issue("hw", found);
    if (found) begin
      chk("hw_strobe", 64'({mem_wren, mem_rden}), 64'(2'b10));
      chk("hw_addr", 64'(mem_addr), 64'(a));
      chk("hw_be", 64'(mem_be), 64'(be));
      chk("hw_wdata", 64'(mem_wdata), 64'(d));
      @(negedge MCLK);
      chk("hw_ack", 64'(host_ack), 64'd1);
    end
    host_req = 1'b0;
    @(negedge MCLK);
    chk("hw_ack_end", 64'(host_ack), 64'd0);
    if (be[0]) shadow[a][7:0]  = d[7:0];
    if (be[1]) shadow[a][15:8] = d[15:8];
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a);
    bit found;
    @(negedge MCLK);
    host_req = 1'b1; host_we = 1'b0; host_addr = a; host_be = 2'($urandom);
    wait_issue("hr", found);
    if (found) begin
      chk("hr_strobe", 64'({mem_wren, mem_rden}), 64'(2'b01));
      chk("hr_addr", 64'(mem_addr), 64'(a));
      for (int i = 0; i < int'(RL); i++) begin
        @(negedge MCLK);
        chk("hr_ack_early", 64'(host_ack), 64'd0);
      end
      @(negedge MCLK);
      chk("hr_ack", 64'(host_ack), 64'd1);
      chk("hr_rdata", 64'(host_rdata), 64'(shadow[a]));
    end
    host_req = 1'b0;
    @(negedge MCLK);
    chk("hr_ack_end", 64'(host_ack), 64'd0);
  endtask

  // full VDP read cycle: address phase, OE fall, data, then CE rise
  task automatic vdp_read(input logic [15:0] a);
    logic [15:0] exp;
    exp = shadow[a[ADDR_W-1:0]];
    @(negedge MCLK);
    vdp_CE = 1'b0; vdp_AD_d = 1'b0; vdp_AD_o = a;
    @(negedge MCLK);
    vdp_OE = 1'b0; vdp_AD_d = 1'b1; vdp_AD_o = 16'($urandom);
    @(negedge MCLK);
    chk("vr_rden_early", 64'(mem_rden), 64'd0);
    @(negedge MCLK);
    chk("vr_rden", 64'({mem_rden, mem_wren}), 64'(2'b10));
    chk("vr_addr", 64'(mem_addr), 64'(a[ADDR_W-1:0]));
    chk("vr_be", 64'(mem_be), 64'(2'b11));
    for (int i = 0; i < int'(RL); i++) begin
      @(negedge MCLK);
      chk("vr_valid_early", 64'(vdp_rd_valid), 64'd0);
    end
    repeat (3) begin
      @(negedge MCLK);
      chk("vr_valid", 64'(vdp_rd_valid), 64'd1);
      chk("vr_data", 64'(vdp_AD_i), 64'(exp));
    end
    vdp_CE = 1'b1; vdp_OE = 1'b1;
    @(negedge MCLK);
    chk("vr_valid_hold", 64'(vdp_rd_valid), 64'd1);
    @(negedge MCLK);
    chk("vr_valid_drop", 64'(vdp_rd_valid), 64'd0);
    vdp_idle();
  endtask

  // VDP write cycle with the given active byte strobes (bit set = strobe low)
  task automatic vdp_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    logic [ADDR_W-1:0] wa;
    wa = a[ADDR_W-1:0];
    @(negedge MCLK);
    vdp_CE = 1'b0; vdp_AD_d = 1'b0; vdp_AD_o = a;
    @(negedge MCLK);
    vdp_AD_o = d; vdp_WE0 = ~be[0]; vdp_WE1 = ~be[1];
    @(negedge MCLK);
    chk("vw_wren_early", 64'(mem_wren), 64'd0);
    @(negedge MCLK);
    chk("vw_wren", 64'({mem_wren, mem_rden}), 64'(2'b10));
    chk("vw_addr", 64'(mem_addr), 64'(wa));
    chk("vw_be", 64'(mem_be), 64'(be));
    chk("vw_wdata", 64'(mem_wdata), 64'(d));
    @(negedge MCLK);
    chk("vw_single", 64'(mem_wren), 64'd0);
    @(negedge MCLK);
    chk("vw_single2", 64'(mem_wren), 64'd0);
    vdp_WE0 = 1'b1; vdp_WE1 = 1'b1; vdp_CE = 1'b1; vdp_AD_d = 1'b1;
    tick(2);
    if (be[0]) shadow[wa][7:0]  = d[7:0];
    if (be[1]) shadow[wa][15:8] = d[15:8];
  endtask

  initial begin
    bit          got;
    logic        seen;
    logic [15:0] d;
    logic [12:0] a13;
    int          op;

    RESET = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = 16'h0; host_be = 2'b00;
    vdp_idle();
    tick(3);
    outs_zero("reset");
    for (int i = 0; i < int'(DEPTH); i++) shadow[i] = ram[i];
    RESET = 1'b1;
    tick(2);

    // VDP read of a known word
    host_write(13'h0123, 16'hBEEF, 2'b11);
    vdp_read(16'h0123);

    // VDP high-byte write at the top address, upper AD bits ignored
    vdp_write(16'hFFFF, 16'hA55A, 2'b10);
    host_read(13'h1FFF);

    // host write/read and zero byte enables
    host_write(13'h0010, 16'h1234, 2'b11);
    host_read(13'h0010);
    host_write(13'h0011, 16'hFFFF, 2'b00);
    host_read(13'h0011);

    // CE fall while the VDP is not driving AD: cycle ignored
    host_write(13'h0004, 16'h4444, 2'b11);
    @(negedge MCLK);
    vdp_CE = 1'b0; vdp_AD_d = 1'b1; vdp_AD_o = 16'h0004;
    @(negedge MCLK);
    vdp_OE = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge MCLK);
      seen = seen | mem_rden | mem_wren;
    end
    chk("ignored_cycle", 64'(seen), 64'd0);
    vdp_idle();
    tick(2);

    // contention: host read requested in the cycle the VDP OE fall is acted on
    @(negedge MCLK);
    vdp_CE = 1'b0; vdp_AD_d = 1'b0; vdp_AD_o = 16'h0123;
    @(negedge MCLK);
    vdp_OE = 1'b0; vdp_AD_d = 1'b1;
    @(negedge MCLK);
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0004; host_be = 2'b11;
    @(negedge MCLK);
    chk("ct_vdp_first", 64'({mem_rden, mem_addr}), 64'({1'b1, 13'h0123}));
    for (int i = 1; i <= int'(RL) + 2; i++) begin
      @(negedge MCLK);
      if (i == 1) chk("ct_host_next", 64'({mem_rden, mem_addr}), 64'({1'b1, 13'h0004}));
      chk("ct_vdp_valid", 64'(vdp_rd_valid), 64'(i >= int'(RL) + 1));
      chk("ct_host_ack", 64'(host_ack), 64'(i == int'(RL) + 2));
      if (i >= int'(RL) + 1) chk("ct_vdp_data", 64'(vdp_AD_i), 64'(shadow[13'h0123]));
      if (i == int'(RL) + 2) chk("ct_host_data", 64'(host_rdata), 64'(shadow[13'h0004]));
    end
    host_req = 1'b0;
    @(negedge MCLK);
    chk("ct_ack_end", 64'(host_ack), 64'd0);
    vdp_idle();
    tick(2);

    // abort: CE rises with a VDP read in flight while the host reads elsewhere
    @(negedge MCLK);
    vdp_CE = 1'b0; vdp_AD_d = 1'b0; vdp_AD_o = 16'h0123;
    @(negedge MCLK);
    vdp_OE = 1'b0; vdp_AD_d = 1'b1;
    tick(2);
    chk("ab_rden", 64'({mem_rden, mem_addr}), 64'({1'b1, 13'h0123}));
    vdp_CE = 1'b1; vdp_OE = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0010; host_be = 2'b11;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge MCLK);
      chk("ab_no_valid", 64'(vdp_rd_valid), 64'd0);
      if (host_ack && !got) begin
        got = 1'b1;
        chk("ab_host_data", 64'(host_rdata), 64'(shadow[13'h0010]));
        host_req = 1'b0;
      end
    end
    chk("ab_host_ack", 64'(got), 64'd1);
    host_req = 1'b0;
    vdp_idle();
    tick(2);

    // reset during V_RWAIT with a host read in flight
    @(negedge MCLK);
    vdp_CE = 1'b0; vdp_AD_d = 1'b0; vdp_AD_o = 16'h0004;
    @(negedge MCLK);
    vdp_OE = 1'b0; vdp_AD_d = 1'b1;
    tick(2);
    chk("rs_vdp_rden", 64'({mem_rden, mem_addr}), 64'({1'b1, 13'h0004}));
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0123; host_be = 2'b11;
    @(negedge MCLK);
    chk("rs_host_rden", 64'({mem_rden, mem_addr}), 64'({1'b1, 13'h0123}));
    RESET = 1'b0;
    #1;
    outs_zero("rs_async");
    host_req = 1'b0;
    vdp_idle();
    seen = 1'b0;
    repeat (int'(RL) + 3) begin
      @(negedge MCLK);
      seen = seen | host_ack | vdp_rd_valid;
    end
    chk("rs_no_ack", 64'(seen), 64'd0);
    RESET = 1'b1;
    tick(2);
    host_read(13'h0123);
    vdp_read(16'h0004);

    // randomized mix checked against the reference contents
    for (int it = 0; it < 40; it++) begin
      op  = int'($urandom_range(0, 3));
      a13 = 13'($urandom_range(0, 31));
      d   = 16'($urandom);
      case (op)
        0:       host_write(a13, d, 2'($urandom_range(0, 3)));
        1:       host_read(a13);
        2:       vdp_write({3'($urandom), a13}, d, 2'($urandom_range(1, 3)));
        default: vdp_read({3'($urandom), a13});
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
